// File: rtl/sd_ring_array.sv
`default_nettype none
// ============================================================================
// Module   : sd_ring_array
// Purpose  : N-channel ring-coupled sigma-delta modulator array. Each channel
//            has a coupling integrator steered by its two ring neighbours'
//            bitstream bits, followed by a gained second-stage quantiser.
//            All arithmetic saturates, and a sticky flag records any clamp.
//            The coupling constant k is updated through a valid/ready
//            handshake and only takes effect at frame boundaries. A
//            per-frame ones-density count is kept for each channel.
// Ports    : clk        rising-edge clock
//            reset      asynchronous active-high reset
//            en         advance modulators and frame counter
//            k_in       signed new k value
//            k_valid    k_in offered
//            k_ready    pending register empty, an offer will be accepted
//            sd_out     bitstream, bit i = channel i
//            ovf        sticky saturation flag per channel
//            frame_done one-cycle pulse on the last cycle of each frame
//            density    ones count per channel over the previous frame
// Revision : 1.0 - initial release
// ============================================================================
module sd_ring_array #(
    parameter int                        NCH       = 3,
    parameter int                        BITWIDTH  = 32,
    parameter int                        POSTGAIN  = 2,
    parameter int                        FRAME_LEN = 16,
    parameter logic [NCH*BITWIDTH-1:0]   SEED      = '0,
    localparam int                       CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic signed [BITWIDTH-1:0]   k_in,
    input  logic                         k_valid,
    output logic                         k_ready,
    output logic [NCH-1:0]               sd_out,
    output logic [NCH-1:0]               ovf,
    output logic                         frame_done,
    output logic [NCH*CW-1:0]            density
);

    // Internal arithmetic is carried wide enough that no intermediate
    // (three-term sum, shifted integrator) can wrap before clamping.
    localparam int XW = 2 * BITWIDTH + 2;
    localparam int FW = $clog2(FRAME_LEN);

    localparam logic signed [XW-1:0] c_one = XW'(1);
    localparam logic signed [XW-1:0] c_max = (c_one <<< (BITWIDTH - 1)) - c_one;
    localparam logic signed [XW-1:0] c_min = -(c_one <<< (BITWIDTH - 1));
    localparam logic signed [XW-1:0] c_fs  = c_one <<< (BITWIDTH - 2);
    localparam logic [FW-1:0]        c_last = FW'(FRAME_LEN - 1);

    function automatic logic signed [XW-1:0] clamp(input logic signed [XW-1:0] v);
        if (v > c_max) begin
            return c_max;
        end else if (v < c_min) begin
            return c_min;
        end
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Frame counter and k handshake
    // ------------------------------------------------------------------
    logic [FW-1:0]               r_fcnt;
    logic signed [BITWIDTH-1:0]  r_k_active;
    logic signed [BITWIDTH-1:0]  r_k_pend;
    logic                        r_pend_full;
    logic signed [XW-1:0]        w_k;

    assign frame_done = en && (r_fcnt == c_last);
    assign k_ready    = ~r_pend_full;
    assign w_k        = XW'(r_k_active);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fcnt      <= '0;
            r_k_active  <= '0;
            r_k_pend    <= '0;
            r_pend_full <= 1'b0;
        end else begin
            if (en) begin
                r_fcnt <= (r_fcnt == c_last) ? '0 : r_fcnt + FW'(1);
            end
            // Promotion and capture are exclusive: capture requires an
            // empty pending register, promotion requires a full one. A
            // capture on the boundary edge therefore waits a whole frame.
            if (frame_done && r_pend_full) begin
                r_k_active  <= r_k_pend;
                r_pend_full <= 1'b0;
            end
            if (k_valid && !r_pend_full) begin
                r_k_pend    <= k_in;
                r_pend_full <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel modulator and density counter
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam int c_nxt = (i + 1) % NCH;
        localparam int c_prv = (i + NCH - 1) % NCH;

        logic signed [BITWIDTH-1:0] r_integ;
        logic signed [BITWIDTH-1:0] r_acc;
        logic                       r_ovf;
        logic [CW-1:0]              r_count;
        logic [CW-1:0]              r_density;

        logic signed [XW-1:0]       w_t1;
        logic signed [XW-1:0]       w_t2;
        logic signed [XW-1:0]       w_fb;
        logic signed [XW-1:0]       w_isum;
        logic signed [XW-1:0]       w_isat;
        logic signed [XW-1:0]       w_graw;
        logic signed [XW-1:0]       w_g;
        logic signed [XW-1:0]       w_qsum;
        logic signed [XW-1:0]       w_qsat;
        logic                       w_clip;

        always_comb begin
            w_t1   = sd_out[c_nxt] ? w_k : -w_k;
            w_t2   = sd_out[c_prv] ? -w_k : w_k;
            w_fb   = sd_out[i] ? -c_one : c_one;
            w_isum = XW'(r_integ) + w_t1 + w_t2 + w_fb;
            w_isat = clamp(w_isum);
            // Quantiser sees the integrator value from before this edge.
            w_graw = XW'(r_integ) <<< POSTGAIN;
            w_g    = clamp(w_graw);
            w_qsum = XW'(r_acc) + w_g - (sd_out[i] ? c_fs : -c_fs);
            w_qsat = clamp(w_qsum);
            w_clip = (w_isat != w_isum) || (w_g != w_graw) || (w_qsat != w_qsum);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_integ   <= '0;
                r_acc     <= SEED[i*BITWIDTH +: BITWIDTH];
                r_ovf     <= 1'b0;
                r_count   <= '0;
                r_density <= '0;
            end else if (en) begin
                r_integ <= BITWIDTH'(w_isat);
                r_acc   <= BITWIDTH'(w_qsat);
                if (w_clip) begin
                    r_ovf <= 1'b1;
                end
                // The last cycle's bit is folded straight into the reported
                // density so a frame of all ones reports FRAME_LEN.
                if (frame_done) begin
                    r_density <= r_count + CW'(sd_out[i]);
                    r_count   <= '0;
                end else if (sd_out[i]) begin
                    r_count <= r_count + CW'(1);
                end
            end
        end

        assign sd_out[i]                = ~r_acc[BITWIDTH-1];
        assign ovf[i]                   = r_ovf;
        assign density[i*CW +: CW]      = r_density;
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_ring_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_ring_array
// Purpose  : Self-checking bench for sd_ring_array. A behavioural model with
//            plain integer arithmetic predicts every cycle's outputs; the
//            driver pushes predictions into a queue and an independent
//            monitor pops and compares them against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_ring_array;

    localparam int NCH = 3;
    localparam int BW  = 32;
    localparam int PG  = 2;
    localparam int FL  = 16;
    localparam int CW  = 5;
    localparam logic [NCH*BW-1:0] SEED = {32'h2000_0000, 32'h8000_0000, 32'h0000_0000};

    localparam longint MAXV = 64'sh7FFF_FFFF;
    localparam longint MINV = -64'sh8000_0000;
    localparam longint FS   = 64'sh4000_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [BW-1:0]     k_in;
    logic              k_valid;
    logic              k_ready;
    logic [NCH-1:0]    sd_out;
    logic [NCH-1:0]    ovf;
    logic              frame_done;
    logic [NCH*CW-1:0] density;

    always #5 clk = ~clk;

    sd_ring_array #(
        .NCH(NCH), .BITWIDTH(BW), .POSTGAIN(PG), .FRAME_LEN(FL), .SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .k_in(k_in), .k_valid(k_valid),
        .k_ready(k_ready), .sd_out(sd_out), .ovf(ovf),
        .frame_done(frame_done), .density(density)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    longint m_integ [NCH];
    longint m_acc   [NCH];
    bit     m_ovf   [NCH];
    int     m_count [NCH];
    int     m_dens  [NCH];
    longint m_k;
    longint m_pend;
    bit     m_full;
    int     m_cnt;

    typedef struct {
        logic [NCH-1:0]    sd;
        logic [NCH-1:0]    ovf;
        logic              rdy;
        logic              fd;
        logic [NCH*CW-1:0] dens;
    } exp_t;

    exp_t exp_q[$];

    function automatic longint clampv(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic void model_reset();
        logic [NCH*BW-1:0] seedv;
        logic [BW-1:0]     slice;
        seedv = SEED;
        for (int i = 0; i < NCH; i++) begin
            slice      = seedv[i*BW +: BW];
            m_integ[i] = 0;
            m_acc[i]   = longint'($signed(slice));
            m_ovf[i]   = 1'b0;
            m_count[i] = 0;
            m_dens[i]  = 0;
        end
        m_k = 0; m_pend = 0; m_full = 1'b0; m_cnt = 0;
    endfunction

    function automatic exp_t model_outputs(input bit e);
        exp_t r;
        for (int i = 0; i < NCH; i++) begin
            r.sd[i]              = (m_acc[i] >= 0);
            r.ovf[i]             = m_ovf[i];
            r.dens[i*CW +: CW]   = CW'(m_dens[i]);
        end
        r.rdy = !m_full;
        r.fd  = e && (m_cnt == FL - 1);
        return r;
    endfunction

    function automatic void model_step(input bit e, input bit kv, input longint kin);
        bit     sd [NCH];
        longint ni [NCH];
        longint na [NCH];
        bit     fd;
        bit     rdy;
        for (int i = 0; i < NCH; i++) sd[i] = (m_acc[i] >= 0);
        fd  = e && (m_cnt == FL - 1);
        rdy = !m_full;
        if (e) begin
            for (int i = 0; i < NCH; i++) begin
                int a;
                int b;
                longint s;
                longint gr;
                longint g;
                longint q;
                a    = (i + 1) % NCH;
                b    = (i + NCH - 1) % NCH;
                s    = m_integ[i] + (sd[a] ? m_k : -m_k) + (sd[b] ? -m_k : m_k) + (sd[i] ? -1 : 1);
                ni[i] = clampv(s);
                gr   = m_integ[i] * (64'sd1 << PG);
                g    = clampv(gr);
                q    = m_acc[i] + g - (sd[i] ? FS : -FS);
                na[i] = clampv(q);
                if (ni[i] != s || g != gr || na[i] != q) m_ovf[i] = 1'b1;
            end
            for (int i = 0; i < NCH; i++) begin
                m_integ[i] = ni[i];
                m_acc[i]   = na[i];
                if (fd) begin
                    m_dens[i]  = m_count[i] + int'(sd[i]);
                    m_count[i] = 0;
                end else if (sd[i]) begin
                    m_count[i]++;
                end
            end
            m_cnt = (m_cnt + 1) % FL;
        end
        if (fd && m_full) begin
            m_k    = m_pend;
            m_full = 1'b0;
        end
        if (kv && rdy) begin
            m_pend = kin;
            m_full = 1'b1;
        end
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".sd_out"},     64'(sd_out),     64'(e.sd));
        check({tag, ".ovf"},        64'(ovf),        64'(e.ovf));
        check({tag, ".k_ready"},    64'(k_ready),    64'(e.rdy));
        check({tag, ".frame_done"}, 64'(frame_done), 64'(e.fd));
        check({tag, ".density"},    64'(density),    64'(e.dens));
    endtask

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic cycle(input bit e, input bit kv, input logic [BW-1:0] kin);
        @(negedge clk);
        en      = e;
        k_valid = kv;
        k_in    = kin;
        exp_q.push_back(model_outputs(e));
        model_step(e, kv, longint'($signed(kin)));
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle(1'b1, 1'b0, '0);
    endtask

    task automatic run_to(input int cnt);
        for (int c = 0; c < FL && m_cnt != cnt; c++) cycle(1'b1, 1'b0, '0);
    endtask

    task automatic async_reset();
        exp_t e;
        @(negedge clk);
        en      = 1'b0;
        k_valid = 1'b0;
        #3;
        reset = 1'b1;
        model_reset();
        e = model_outputs(1'b0);
        #1;
        check_outputs("async_reset", e);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops one prediction per cycle, between clock edges
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) check_outputs("cycle", exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] r;
        bit          e;
        bit          kv;

        reset = 1'b1; en = 1'b0; k_valid = 1'b0; k_in = '0;
        model_reset();
        #1;
        check_outputs("reset", model_outputs(1'b0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // k = 0 free-running for four frames
        run(4 * FL);

        // Handshake: offer at count 3, a second offer while busy
        run_to(3);
        cycle(1'b1, 1'b1, 32'h0010_0000);
        for (int c = 0; c < 3; c++) cycle(1'b1, 1'b1, 32'h00AB_CDEF);
        run(2 * FL);

        // Offer exactly on the frame_done cycle
        run_to(FL - 1);
        cycle(1'b1, 1'b1, 32'hFFF0_0000);
        run(2 * FL + 3);

        // Hold for ten cycles mid-frame, offering during the hold
        run_to(7);
        for (int c = 0; c < 10; c++) cycle(1'b0, (c == 4), 32'h0002_0000);
        run(2 * FL);

        // Randomised stretch with moderate k magnitudes
        for (int c = 0; c < 30 * FL; c++) begin
            r  = $urandom;
            e  = ($urandom_range(0, 9) != 0);
            kv = ($urandom_range(0, 3) == 0);
            cycle(e, kv, {{12{r[19]}}, r[19:0]});
        end

        // Saturation: full-scale k, then back to zero
        run_to(2);
        cycle(1'b1, 1'b1, 32'h7FFF_FFFF);
        run(2 * FL);
        cycle(1'b1, 1'b1, 32'h0000_0000);
        run(2 * FL);

        // Asynchronous reset mid-frame with a k pending
        run_to(5);
        cycle(1'b1, 1'b1, 32'h0030_0000);
        run(3);
        async_reset();
        run(FL);

        // Most negative k after reset
        cycle(1'b1, 1'b1, 32'h8000_0000);
        run(3 * FL);

        repeat (2) @(negedge clk);
        #3;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
